pc_seq: RTL and testbench

- Fetch sequencer that owns the program counter for the multi-cycle/memory-latency variant of the CPU.
- Issues instruction-memory requests over a req/gnt + rvalid handshake and presents each fetched instruction to the core.
- Waits for the core's completion strobe, then resolves the next PC from npc_op/imm/ra: PC+4, branch, jump or register jump.
- Sits between the instruction memory port and the decode/control unit; replaces the free-running PC register.

---
 rtl/pc_seq_pkg.sv | 19 +
 rtl/pc_seq_next_pc_calc.sv | 35 +++
 rtl/pc_seq.sv | 126 ++++++++++++
 tb/tb_pc_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch sequencer and its next-PC helper.
//   NPC_*   : next-PC select encodings, driven by the control unit on npc_op
//   state_t : sequencer FSM encoding, also exported on the pc_seq debug port
package pc_seq_pkg;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_RA     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_EXEC     = 3'd3,
    ST_ERR      = 3'd4
  } state_t;

endpackage

// File: rtl/pc_seq_next_pc_calc.sv
// Combinational next-PC resolver, shared with the single-cycle core.
//   pc     : address of the instruction being retired
//   npc_op : PLUS4 / BRANCH / JUMP / RA select
//   imm    : 26-bit immediate field (branch uses imm[15:0])
//   ra     : register-jump target
//   npc    : resolved next PC (all arithmetic wraps modulo 2^32)
module next_pc_calc
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic [25:0] imm,
  input  logic [31:0] ra,
  output logic [31:0] npc
);

  logic [31:0] p4;
  logic [31:0] boff;

  assign p4   = pc + 32'd4;
  // Branch offset is a signed word count, turned into a byte offset.
  assign boff = {{14{imm[15]}}, imm[15:0], 2'b00};

  always_comb begin
    npc = p4;
    case (npc_op)
      NPC_PLUS4:  npc = p4;
      NPC_BRANCH: npc = p4 + boff;
      NPC_JUMP:   npc = {p4[31:28], imm, 2'b00};
      NPC_RA:     npc = ra;
      default:    npc = p4;
    endcase
  end

endmodule

// File: rtl/pc_seq.sv
// Fetch sequencer: owns the architectural PC, fetches one instruction at a
// time from instruction memory, holds it for the core and resolves the next
// PC when the core retires it.
//   clk, rst                       : clock, synchronous active-high reset
//   imem_req/imem_addr/imem_gnt    : fetch request channel
//   imem_rvalid/imem_rdata         : fetch response channel
//   inst_valid/inst/inst_pc        : instruction presented to the core
//   stall/done/npc_op/imm/ra       : retire strobe and next-PC inputs
//   pc, misalign                   : architectural PC, sticky misalign flag
//   state                          : FSM state (debug observation)
//
// Handshakes: a request transfers on a rising edge where imem_req=1 and
// imem_gnt=1; imem_addr is held stable while imem_req=1 without grant. The
// response is a single-cycle imem_rvalid pulse, accepted only in WAIT_RSP.
// The core retires on an edge with done=1 and stall=0 while inst_valid=1.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_3000,
  parameter int unsigned DONE_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        stall,
  input  logic        done,
  input  logic [1:0]  npc_op,
  input  logic [25:0] imm,
  input  logic [31:0] ra,
  output logic [31:0] pc,
  output logic        misalign,
  output state_t      state
);

  logic [31:0] npc;
  logic [31:0] tmo_cnt;
  logic        retire;
  logic        ra_bad;
  logic        tmo_hit;

  next_pc_calc u_next_pc_calc (
    .pc     (inst_pc),
    .npc_op (npc_op),
    .imm    (imm),
    .ra     (ra),
    .npc    (npc)
  );

  assign imem_addr = pc;
  // stall overrides done: the core must be ready for the retire to count.
  assign retire    = done && !stall;
  assign ra_bad    = (npc_op == NPC_RA) && (ra[1:0] != 2'b00);
  // tmo_cnt counts completed EXEC cycles without retire; the limit is hit
  // on the edge that ends the DONE_TIMEOUT-th such cycle.
  assign tmo_hit   = (DONE_TIMEOUT != 0) && (tmo_cnt == DONE_TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= 32'd0;
      inst_pc    <= 32'd0;
      misalign   <= 1'b0;
      tmo_cnt    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_REQ;
          imem_req <= 1'b1;
        end
        ST_REQ: begin
          if (imem_gnt) begin
            state    <= ST_WAIT_RSP;
            imem_req <= 1'b0;
          end
        end
        ST_WAIT_RSP: begin
          if (imem_rvalid) begin
            inst       <= imem_rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            tmo_cnt    <= 32'd0;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (retire) begin
            inst_valid <= 1'b0;
            if (ra_bad) begin
              // PC is left at the faulting instruction's fetch address.
              misalign <= 1'b1;
              state    <= ST_ERR;
            end else begin
              pc       <= npc;
              imem_req <= 1'b1;
              state    <= ST_REQ;
            end
          end else if (tmo_hit) begin
            inst_valid <= 1'b0;
            state      <= ST_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        ST_ERR: begin
          // Frozen until reset.
        end
        default: begin
          state      <= ST_ERR;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: memory/core driver tasks, a monitor that pops expected
// fetch addresses and instructions from queues, and a PC reference model.
module tb_pc_seq;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        stall;
  logic        done;
  logic [1:0]  npc_op;
  logic [25:0] imm;
  logic [31:0] ra;
  logic [31:0] pc;
  logic        misalign;
  state_t      state;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_ipc_q[$];
  logic [31:0] mpc;

  pc_seq dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .stall(stall), .done(done), .npc_op(npc_op), .imm(imm), .ra(ra),
    .pc(pc), .misalign(misalign), .state(state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference next-PC from the architectural rules, using integer arithmetic.
  function automatic logic [31:0] ref_npc(input logic [31:0] ipc, input logic [1:0] op,
                                          input logic [25:0] im, input logic [31:0] r);
    logic [31:0] p4;
    logic signed [15:0] s16;
    int off;
    p4  = ipc + 32'd4;
    s16 = im[15:0];
    off = int'(s16) * 4;
    case (op)
      2'd0:    return p4;
      2'd1:    return p4 + 32'(off);
      2'd2:    return (p4 & 32'hF000_0000) + 32'(im) * 32'd4;
      default: return r;
    endcase
  endfunction

  // Monitor: samples 1ns before each rising edge.
  initial begin
    logic        prev_iv, prev_req, prev_gnt;
    logic [31:0] prev_addr, last_inst, last_ipc;
    prev_iv = 0; prev_req = 0; prev_gnt = 0;
    prev_addr = 0; last_inst = 0; last_ipc = 0;
    forever begin
      @(negedge clk); #4;
      if (rst) begin
        prev_iv = 0; prev_req = 0; prev_gnt = 0;
        last_inst = 0; last_ipc = 0;
      end else begin
        if (imem_req && prev_req && !prev_gnt)
          chk("addr_stable", imem_addr, prev_addr);
        if (imem_req && imem_gnt) begin
          if (exp_addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_fetch: got addr %h expected no request", imem_addr);
          end else begin
            chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
          end
        end
        if (inst_valid && !prev_iv) begin
          if (exp_inst_q.size() == 0 || exp_ipc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_inst: got inst %h expected none", inst);
          end else begin
            last_inst = exp_inst_q.pop_front();
            last_ipc  = exp_ipc_q.pop_front();
          end
        end
        chk("inst", inst, last_inst);
        chk("inst_pc", inst_pc, last_ipc);
        prev_iv = inst_valid; prev_req = imem_req;
        prev_gnt = imem_gnt; prev_addr = imem_addr;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_iv", 32'(inst_valid), 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_misalign", 32'(misalign), 0);
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    rst = 1'b0;
    mpc = 32'h0000_3000;
    exp_addr_q.delete(); exp_inst_q.delete(); exp_ipc_q.delete();
  endtask

  task automatic fetch(input logic [31:0] data, input int gdly, input int rdly, input bit spur);
    int n;
    exp_addr_q.push_back(mpc);
    n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      chk("req_wait", 32'(imem_req), 1);
      return;
    end
    for (int i = 0; i < gdly; i++) begin
      if (spur && i == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
      end
      @(negedge clk);
      imem_rvalid = 1'b0;
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    chk("req_drop", 32'(imem_req), 0);
    for (int i = 0; i < rdly; i++) @(negedge clk);
    exp_inst_q.push_back(data);
    exp_ipc_q.push_back(mpc);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk("inst_valid_rise", 32'(inst_valid), 1);
  endtask

  task automatic retire(input logic [1:0] op, input logic [25:0] im, input logic [31:0] r,
                        input int stalls);
    logic [31:0] npc;
    done = 1'b1; stall = 1'b1; npc_op = op; imm = im; ra = r;
    for (int i = 0; i < stalls; i++) begin
      @(negedge clk);
      chk("stall_pc", pc, mpc);
      chk("stall_iv", 32'(inst_valid), 1);
    end
    stall = 1'b0;
    @(negedge clk);
    done = 1'b0; npc_op = 2'($urandom); imm = 26'($urandom); ra = $urandom;
    npc = ref_npc(mpc, op, im, r);
    chk("retire_iv", 32'(inst_valid), 0);
    if (op == 2'd3 && r[1:0] != 2'b00) begin
      chk("misalign_flag", 32'(misalign), 1);
      chk("misalign_state", 32'(state), 32'(ST_ERR));
      chk("misalign_pc", pc, mpc);
    end else begin
      mpc = npc;
      chk("next_pc", pc, mpc);
      chk("next_req", 32'(imem_req), 1);
      chk("next_addr", imem_addr, mpc);
    end
  endtask

  task automatic step(input logic [1:0] op, input logic [25:0] im, input logic [31:0] r);
    fetch($urandom, 0, 0, 1'b0);
    retire(op, im, r, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    rst = 1'b1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    stall = 0; done = 0; npc_op = 0; imm = 0; ra = 0;
    do_reset();

    // first fetch at the reset PC, then sequential flow to 0x3010
    fetch(32'hDEAD_0001, 1, 1, 1'b0);
    retire(2'd0, 26'd0, 32'd0, 0);
    chk("plus4_first", pc, 32'h0000_3004);
    step(2'd0, 0, 0); step(2'd0, 0, 0); step(2'd0, 0, 0);
    chk("at_3010", mpc, 32'h0000_3010);
    step(2'd1, 26'h000_FFFC, 0);
    chk("branch_back", pc, 32'h0000_3004);
    step(2'd0, 0, 0); step(2'd0, 0, 0); step(2'd0, 0, 0);
    step(2'd2, 26'h000_0C04, 0);
    chk("jump", pc, 32'h0000_3010);
    step(2'd3, 0, 32'h0000_3040);
    chk("reg_jump", pc, 32'h0000_3040);

    // stalled retire, then slow memory with a spurious response in REQ
    fetch(32'hCAFE_0002, 0, 0, 1'b0);
    retire(2'd0, 0, 0, 4);
    chk("stall_then_retire", pc, 32'h0000_3044);
    fetch(32'hCAFE_0003, 5, 3, 1'b1);
    retire(2'd0, 0, 0, 0);

    // randomized flow
    for (int k = 0; k < 40; k++) begin
      r = $urandom;
      r[1:0] = 2'b00;
      fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      retire(2'($urandom_range(0, 3)), 26'($urandom), r, $urandom_range(0, 2));
    end

    // PC wrap
    step(2'd3, 0, 32'hFFFF_FFFC);
    step(2'd0, 0, 0);
    chk("wrap_pc", pc, 32'h0000_0000);
    step(2'd0, 0, 0);
    chk("post_wrap", pc, 32'h0000_0004);

    // reset while waiting for the response, then a late response
    exp_addr_q.push_back(mpc);
    while (!imem_req) @(negedge clk);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    chk("mid_state", 32'(state), 32'(ST_WAIT_RSP));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_pc", pc, 32'h0000_3000);
    chk("midrst_iv", 32'(inst_valid), 0);
    chk("midrst_state", 32'(state), 32'(ST_IDLE));
    mpc = 32'h0000_3000;
    exp_addr_q.delete(); exp_inst_q.delete(); exp_ipc_q.delete();
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("late_rvalid_iv", 32'(inst_valid), 0);

    // misaligned register jump -> ERR, frozen
    fetch(32'h1234_5678, 0, 0, 1'b0);
    retire(2'd3, 0, 32'h0000_3042, 0);
    for (int i = 0; i < 20; i++) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_gnt    = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("err_req", 32'(imem_req), 0);
      chk("err_iv", 32'(inst_valid), 0);
      chk("err_state", 32'(state), 32'(ST_ERR));
      chk("err_pc", pc, 32'h0000_3000);
    end
    imem_rvalid = 1'b0; imem_gnt = 1'b0;

    // reset out of ERR
    do_reset();
    step(2'd0, 0, 0);
    chk("recover_pc", pc, 32'h0000_3004);

    repeat (2) @(negedge clk);
    chk("queues_empty", 32'(exp_addr_q.size() + exp_inst_q.size() + exp_ipc_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
